// File: rtl/tick_timer_pkg.sv
// Shared types and constants for the programmable tick timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tick_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tt_state_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // 1 Hz at a 100 MHz CLK.
  localparam int unsigned DEFAULT_PERIOD = 100_000_000;

endpackage

// File: rtl/tick_pulse_stretch.sv
// Stretches a one-cycle expiry strobe into a tick pulse of min(PULSE_LEN, period) cycles.
// Latency: tick rises on the edge that samples expire.
// Backpressure: none; a new expire during a pulse restarts the pulse.
//
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   expire    interval expiry strobe
//   clear     drop the pulse immediately (timer stopped)
//   period    effective period of the interval that just expired (>= 1)
//   tick      registered pulse output
module tick_pulse_stretch #(
  parameter int unsigned PERIOD_W  = 32,
  parameter int unsigned PULSE_LEN = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                expire,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam int unsigned CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic [CW-1:0] remain;
  logic [CW-1:0] len_m1;

  // A pulse longer than the period would merge into the next one anyway;
  // clamping keeps tick continuously high rather than overshooting.
  always_comb begin
    len_m1 = CW'(PULSE_LEN - 1);
    if (period < PERIOD_W'(PULSE_LEN)) begin
      len_m1 = CW'(period - PERIOD_W'(1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      tick   <= 1'b0;
      remain <= '0;
    end else if (expire) begin
      tick   <= 1'b1;
      remain <= len_m1;
    end else if (remain != '0) begin
      remain <= remain - CW'(1);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_timer_prog.sv
// Programmable tick generator: periodic or one-shot, double-buffered period, tick counter.
// Latency: start accepted at edge k gives the first tick after edge k+P (P=0 acts as 1).
// Backpressure: load_ready low while a shadow period waits for the next expiry.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   start, stop, mode        control (stop beats start; mode 1 = one-shot, latched at start)
//   load_valid/load_period   period offer, accepted on load_valid && load_ready
//   load_ready               shadow register free
//   tick, busy, done         pulse output, running flag, sticky one-shot completion
//   tick_count               expiries since the last start (wraps)
// Optional build macro TICK_TIMER_PRESCALE_EN adds parameter PRESCALE: the interval
// counter then advances once per PRESCALE cycles (pulse width stays in CLK cycles).
module tick_timer_prog #(
  parameter int unsigned PERIOD_W       = 32,
  parameter int unsigned DEFAULT_PERIOD = tick_timer_pkg::DEFAULT_PERIOD,
  parameter int unsigned PULSE_LEN      = 1,
  parameter int unsigned CNT_W          = 16
`ifdef TICK_TIMER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE       = 1
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic                load_valid,
  input  logic [PERIOD_W-1:0] load_period,
  output logic                load_ready,
  output logic                tick,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    tick_count
);

  import tick_timer_pkg::*;

  tt_state_t           state;
  logic                run_mode;
  logic [PERIOD_W-1:0] counter;
  logic [PERIOD_W-1:0] active_period;
  logic [PERIOD_W-1:0] shadow_period;
  logic                shadow_vld;
  logic [PERIOD_W-1:0] period_eff;
  logic                advance;
  logic                expiry;
  logic                start_acc;
  logic                stop_acc;
  logic                load_acc;

  assign period_eff = (active_period == '0) ? PERIOD_W'(1) : active_period;
  assign load_ready = ~shadow_vld;
  assign load_acc   = load_valid && load_ready;
  assign stop_acc   = stop && (state == RUN);
  assign start_acc  = start && !stop && (state == IDLE);
  // stop takes priority over an expiry landing on the same edge.
  assign expiry     = (state == RUN) && !stop && advance &&
                      (counter == period_eff - PERIOD_W'(1));

`ifdef TICK_TIMER_PRESCALE_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] ps_cnt;

  assign advance = (ps_cnt == PS_W'(PRESCALE - 1));

  // Restarted on start/stop so every interval is a whole number of prescale periods.
  always_ff @(posedge CLK) begin
    if (RST || start_acc || stop_acc || advance) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      tick_count    <= '0;
      counter       <= '0;
      active_period <= PERIOD_W'(DEFAULT_PERIOD);
      shadow_period <= '0;
      shadow_vld    <= 1'b0;
      run_mode      <= MODE_PERIODIC;
    end else begin
      case (state)
        IDLE: begin
          // Nothing is timing, so a new period can take effect directly.
          if (load_acc) begin
            active_period <= load_period;
          end
          if (start_acc) begin
            state      <= RUN;
            busy       <= 1'b1;
            counter    <= '0;
            tick_count <= '0;
            done       <= 1'b0;
            run_mode   <= mode;
          end
        end
        RUN: begin
          if (stop) begin
            state      <= IDLE;
            busy       <= 1'b0;
            counter    <= '0;
            shadow_vld <= 1'b0;
            // Commit the newest pending period so it is not lost on the way to IDLE.
            if (load_acc) begin
              active_period <= load_period;
            end else if (shadow_vld) begin
              active_period <= shadow_period;
            end
          end else begin
            if (advance) begin
              counter <= expiry ? '0 : counter + PERIOD_W'(1);
            end
            if (expiry) begin
              tick_count <= tick_count + CNT_W'(1);
              // Swap only at an interval boundary so no interval is cut or stretched.
              if (shadow_vld) begin
                active_period <= shadow_period;
                shadow_vld    <= 1'b0;
              end
              if (run_mode == MODE_ONESHOT) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
            // load_acc implies the shadow was empty, so this never races the swap above.
            if (load_acc) begin
              shadow_period <= load_period;
              shadow_vld    <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tick_pulse_stretch #(
    .PERIOD_W  (PERIOD_W),
    .PULSE_LEN (PULSE_LEN)
  ) u_stretch (
    .CLK    (CLK),
    .RST    (RST),
    .expire (expiry),
    .clear  (stop_acc),
    .period (period_eff),
    .tick   (tick)
  );

endmodule

// File: tb/tb_tick_timer_prog.sv
// Scoreboard bench for tick_timer_prog: stimulus queues expected per-cycle values and
// expected tick rising edges; a monitor on the falling clock edge pops and compares.
// DUT built with PULSE_LEN=3, CNT_W=4, DEFAULT_PERIOD=6.
module tb_tick_timer_prog;

  localparam int PW = 16;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic          load_valid = 1'b0;
  logic [PW-1:0] load_period = '0;
  logic          load_ready;
  logic          tick;
  logic          busy;
  logic          done;
  logic [CW-1:0] tick_count;

  tick_timer_prog #(
    .PERIOD_W       (PW),
    .DEFAULT_PERIOD (6),
    .PULSE_LEN      (3),
    .CNT_W          (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .load_valid  (load_valid),
    .load_period (load_period),
    .load_ready  (load_ready),
    .tick        (tick),
    .busy        (busy),
    .done        (done),
    .tick_count  (tick_count)
  );

  always #5 CLK = ~CLK;

  // cyc == n between edge n and edge n+1.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  localparam int S_TICK = 0, S_BUSY = 1, S_DONE = 2, S_CNT = 3, S_LR = 4;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } chk_t;

  typedef struct {
    int cyc;
    int cnt;
  } rise_t;

  chk_t  chk_q[$];
  rise_t rise_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  tick_prev = 1'b0;

  function automatic int sig_val(input int s);
    case (s)
      S_TICK:  return int'(tick);
      S_BUSY:  return int'(busy);
      S_DONE:  return int'(done);
      S_CNT:   return int'(tick_count);
      default: return int'(load_ready);
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_TICK:  return "tick";
      S_BUSY:  return "busy";
      S_DONE:  return "done";
      S_CNT:   return "tick_count";
      default: return "load_ready";
    endcase
  endfunction

  // Insert keeping the queue sorted by cycle.
  task automatic expect_at(input int c, input int s, input int v, input string nm);
    chk_t e;
    int   idx;
    e.cyc = c; e.sig = s; e.val = v; e.name = nm;
    idx = chk_q.size();
    for (int i = 0; i < chk_q.size(); i++) begin
      if (chk_q[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    chk_q.insert(idx, e);
  endtask

  task automatic expect_all(input int c, input int t, input int b, input int d,
                            input int n, input int lr, input string nm);
    expect_at(c, S_TICK, t, nm);
    expect_at(c, S_BUSY, b, nm);
    expect_at(c, S_DONE, d, nm);
    expect_at(c, S_CNT, n, nm);
    expect_at(c, S_LR, lr, nm);
  endtask

  task automatic expect_rise(input int c, input int n);
    rise_t r;
    r.cyc = c; r.cnt = n;
    rise_q.push_back(r);
  endtask

  task automatic to_edge(input int c);
    while (cyc < c - 1) @(negedge CLK);
  endtask

  // Present inputs so that edge c samples them for exactly one cycle.
  task automatic drive(input int c, input logic st, input logic sp, input logic ld,
                       input int val, input logic m, input logic rs);
    to_edge(c);
    start = st; stop = sp; load_valid = ld; load_period = PW'(val); RST = rs;
    if (st) mode = m;
    @(negedge CLK);
    start = 1'b0; stop = 1'b0; load_valid = 1'b0; RST = 1'b0;
  endtask

  task automatic do_start(input int c, input logic m); drive(c, 1'b1, 1'b0, 1'b0, 0, m, 1'b0); endtask
  task automatic do_stop(input int c);                 drive(c, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0); endtask
  task automatic do_load(input int c, input int v);    drive(c, 1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0); endtask
  task automatic do_rst(input int c);                  drive(c, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1); endtask

  // Monitor: tick rising edges against rise_q, per-cycle values against chk_q.
  chk_t  mc;
  rise_t mr;
  int    act;
  always @(negedge CLK) begin
    while (rise_q.size() > 0 && rise_q[0].cyc < cyc) begin
      mr = rise_q.pop_front();
      checks++; failures++;
      $display("FAIL tick_rise_missing got=no_rise_by_cyc_%0d want=rise_at_cyc_%0d", cyc, mr.cyc);
    end
    if (tick && !tick_prev) begin
      checks++;
      if (rise_q.size() == 0) begin
        failures++;
        $display("FAIL tick_rise_unexpected got=rise_at_cyc_%0d want=no_rise", cyc);
      end else begin
        mr = rise_q.pop_front();
        if (mr.cyc != cyc || int'(tick_count) != mr.cnt) begin
          failures++;
          $display("FAIL tick_rise got=cyc_%0d_count_%0d want=cyc_%0d_count_%0d",
                   cyc, tick_count, mr.cyc, mr.cnt);
        end
      end
    end
    tick_prev = tick;
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      mc = chk_q.pop_front();
      act = sig_val(mc.sig);
      checks++;
      if (act != mc.val) begin
        failures++;
        $display("FAIL %s cyc=%0d %s got=%0d want=%0d", mc.name, cyc, sig_name(mc.sig), act, mc.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  int k, k2;
  initial begin
    @(negedge CLK);
    expect_all(3, 0, 0, 0, 0, 1, "reset_state");
    while (cyc < 3) @(negedge CLK);
    RST = 1'b0;

    // Default period (6) after reset.
    k = cyc + 1;
    expect_at(k, S_BUSY, 1, "default_busy");
    expect_rise(k + 6, 1);
    expect_rise(k + 12, 2);
    expect_all(k + 13, 0, 0, 0, 2, 1, "default_stop");
    do_start(k, 1'b0);
    do_stop(k + 13);

    // P=5 periodic: expiries at k+5, k+10, k+15; stop mid-pulse clears tick.
    do_load(cyc + 1, 5);
    k = cyc + 1;
    expect_rise(k + 5, 1); expect_rise(k + 10, 2); expect_rise(k + 15, 3);
    expect_at(k + 5, S_CNT, 1, "p5_cnt1");
    expect_at(k + 10, S_CNT, 2, "p5_cnt2");
    expect_at(k + 15, S_CNT, 3, "p5_cnt3");
    expect_at(k + 7, S_TICK, 1, "p5_pulse_end");
    expect_at(k + 8, S_TICK, 0, "p5_pulse_off");
    expect_all(k + 16, 0, 0, 0, 3, 1, "p5_stop");
    do_start(k, 1'b0);
    do_stop(k + 16);

    // P=8: tick high 3 of every 8 cycles.
    do_load(cyc + 1, 8);
    k = cyc + 1;
    expect_rise(k + 8, 1); expect_rise(k + 16, 2); expect_rise(k + 24, 3);
    for (int i = 0; i < 8; i++) expect_at(k + 8 + i, S_TICK, (i < 3) ? 1 : 0, "p8_duty");
    expect_all(k + 25, 0, 0, 0, 3, 1, "p8_stop");
    do_start(k, 1'b0);
    do_stop(k + 25);

    // P=2 with a 3-cycle pulse: tick continuously high.
    do_load(cyc + 1, 2);
    k = cyc + 1;
    expect_rise(k + 2, 1);
    for (int i = 2; i <= 10; i++) expect_at(k + i, S_TICK, 1, "p2_continuous");
    expect_at(k + 10, S_CNT, 5, "p2_cnt");
    expect_all(k + 11, 0, 0, 0, 5, 1, "p2_stop");
    do_start(k, 1'b0);
    do_stop(k + 11);

    // One-shot P=4: single tick, pulse completes in IDLE, done sticky until next start.
    do_load(cyc + 1, 4);
    k = cyc + 1;
    k2 = k + 14;
    expect_all(k, 0, 1, 0, 0, 1, "os_started");
    expect_at(k + 3, S_BUSY, 1, "os_busy_before");
    expect_rise(k + 4, 1);
    expect_all(k + 4, 1, 0, 1, 1, 1, "os_expiry");
    expect_at(k + 6, S_TICK, 1, "os_pulse_in_idle");
    expect_at(k + 7, S_TICK, 0, "os_pulse_off");
    expect_at(k + 12, S_DONE, 1, "os_done_sticky");
    expect_all(k2, 0, 1, 0, 0, 1, "os_restart_clears_done");
    expect_all(k2 + 2, 0, 0, 0, 0, 1, "os_restart_stop");
    do_start(k, 1'b1);
    do_start(k2, 1'b0);
    do_stop(k2 + 2);

    // P=10, shadow load of 4 mid-interval; then a pending load committed by stop.
    do_load(cyc + 1, 10);
    k = cyc + 1;
    expect_rise(k + 10, 1); expect_rise(k + 20, 2);
    expect_rise(k + 24, 3); expect_rise(k + 28, 4);
    expect_at(k + 12, S_LR, 1, "shadow_free");
    expect_at(k + 13, S_LR, 0, "shadow_full");
    expect_at(k + 19, S_LR, 0, "shadow_held");
    expect_at(k + 20, S_LR, 1, "shadow_swapped");
    expect_at(k + 29, S_LR, 0, "shadow_full2");
    expect_all(k + 31, 0, 0, 0, 4, 1, "stop_commit");
    k2 = k + 33;
    expect_rise(k2 + 7, 1);
    expect_all(k2 + 8, 0, 0, 0, 1, 1, "committed_p7_stop");
    do_start(k, 1'b0);
    do_load(k + 13, 4);
    do_load(k + 29, 7);
    do_stop(k + 31);
    do_start(k2, 1'b0);
    do_stop(k2 + 8);

    // start && stop together in IDLE: stays idle, no tick.
    k = cyc + 1;
    expect_all(k, 0, 0, 0, 1, 1, "start_stop_idle");
    expect_all(k + 10, 0, 0, 0, 1, 1, "start_stop_idle_later");
    drive(k, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    to_edge(k + 11);

    // Restart while running is ignored; RST during a pulse with a shadow pending.
    k = cyc + 1;
    k2 = k + 10;
    expect_rise(k + 7, 1);
    expect_at(k + 7, S_LR, 0, "load_on_expiry");
    expect_all(k + 8, 0, 0, 0, 0, 1, "rst_mid_pulse");
    expect_at(k2 + 5, S_CNT, 0, "rst_default_pre");
    expect_rise(k2 + 6, 1);
    do_start(k, 1'b0);
    do_start(k + 3, 1'b0);
    do_load(k + 7, 3);
    do_rst(k + 8);
    do_start(k2, 1'b0);
    do_stop(k2 + 7);

    // P=1 for 17 expiries: tick_count wraps 15 -> 0 -> 1.
    do_load(cyc + 1, 1);
    k = cyc + 1;
    expect_rise(k + 1, 1);
    expect_at(k + 15, S_CNT, 15, "wrap_15");
    expect_at(k + 16, S_CNT, 0, "wrap_0");
    expect_at(k + 16, S_TICK, 1, "wrap_tick");
    expect_at(k + 17, S_CNT, 1, "wrap_1");
    expect_all(k + 18, 0, 0, 0, 1, 1, "wrap_stop");
    do_start(k, 1'b0);
    do_stop(k + 18);

    // P=0 behaves as P=1.
    do_load(cyc + 1, 0);
    k = cyc + 1;
    expect_rise(k + 1, 1);
    expect_at(k + 3, S_CNT, 3, "p0_cnt");
    expect_at(k + 3, S_TICK, 1, "p0_tick");
    expect_all(k + 4, 0, 0, 0, 3, 1, "p0_stop");
    do_start(k, 1'b0);
    do_stop(k + 4);

    to_edge(cyc + 6);
    @(negedge CLK);
    checks++;
    if (rise_q.size() != 0) begin
      failures++;
      $display("FAIL rise_queue_drained got=%0d want=0", rise_q.size());
    end
    checks++;
    if (chk_q.size() != 0) begin
      failures++;
      $display("FAIL check_queue_drained got=%0d want=0", chk_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_timer_prog.md
Name: tick_timer_prog

Overview:
- Programmable tick generator. Successor of the fixed 1 s FPGA test timer: run-time period, periodic or one-shot mode, configurable pulse width, and a tick counter.
- Drives register-stepping and display-refresh strobes in FPGA bring-up builds.
- Period changes are double-buffered, so a running timer never produces a short or long interval.

Parameters:
- PERIOD_W, 32, width of period and interval counter.
- DEFAULT_PERIOD, 100000000, period value loaded at reset (1 Hz at 100 MHz).
- PULSE_LEN, 1, tick high time in cycles (>=1).
- CNT_W, 16, width of tick_count.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  reset; synchronous and active-high.
- start  in  1  one-cycle request to begin counting.
- stop  in  1  one-cycle request to halt.
- mode  in  1  0 = periodic, 1 = one-shot; sampled when start is accepted.
- load_valid  in  1  new period offered.
- load_period  in  PERIOD_W  offered period value.
- load_ready  out  1  shadow register free; load accepted on valid&&ready.
- tick  out  1  output pulse.
- busy  out  1  high in RUN.
- done  out  1  sticky one-shot completion flag.
- tick_count  out  CNT_W  number of expiries since the last start.

Behaviour:
- Reset values: tick=0, busy=0, done=0, tick_count=0, load_ready=1, counter=0, active period=DEFAULT_PERIOD, shadow empty, state IDLE.
- RST mid-operation aborts everything in the same edge, including any pulse in progress.
- Period P: tick rises every P cycles. P=0 is treated as P=1; tick then stays high continuously while running in periodic mode.
- States:
  - IDLE: start accepted -> RUN. Edge k: counter<=0, tick_count<=0, done<=0, mode latched.
  - RUN: counter increments each cycle. At counter==P-1 (expiry), counter<=0 and tick_count increments, wrapping at 2^CNT_W.
  - Expiry in periodic mode: stay in RUN.
  - Expiry in one-shot mode: go to IDLE and set done<=1.
- Latency: with start accepted at edge k, the first tick is high after edge k+P. Subsequent ticks follow every P cycles.
- Pulse: a separate down-counter holds tick high for min(PULSE_LEN, P) cycles after each expiry. An expiry during a pulse restarts the pulse counter. In one-shot mode the pulse completes even after the return to IDLE.
- stop in RUN -> IDLE next edge: tick<=0, counter<=0, pulse cleared. tick_count and done are held.
- start && stop in the same cycle: stop wins. start while already in RUN is ignored.
- Load handshake:
  - IDLE: an accepted load writes the active period directly; load_ready stays 1.
  - RUN: an accepted load writes a one-deep shadow and load_ready drops to 0. The shadow becomes active at the next expiry, then load_ready returns to 1.
  - stop with a shadow pending: the shadow is committed to the active period at the transition to IDLE.
- busy = (state==RUN), registered.

Optional Feature:
- Macro: TICK_TIMER_PRESCALE_EN.
- Defined: adds parameter PRESCALE (default 1) and a free-running prescale counter; the interval counter advances only on prescale wrap, so the effective period is P*PRESCALE cycles. The prescaler is cleared on start, stop and RST. Pulse width stays in raw CLK cycles.
- Undefined: no prescaler logic; the counter advances every cycle.

Decomposition:
- Package tick_timer_pkg: state enum (IDLE, RUN), mode constants MODE_PERIODIC/MODE_ONESHOT, DEFAULT_PERIOD constant.
- One natural sub-module: tick_pulse_stretch (PULSE_LEN down-counter producing tick from the expiry strobe).

Test Plan:
- RST, then P=5 loaded in IDLE, mode=0, start at edge 10 -> tick high after edges 15, 20, 25; tick_count 1, 2, 3.
- PULSE_LEN=3, P=8, periodic -> tick high exactly 3 cycles out of every 8; P=2 -> tick constantly high.
- One-shot, P=4 -> single tick 4 cycles after start; busy falls the same edge; done=1 until the next start; tick_count=1.
- Running P=10, load P=3 mid-interval -> load_ready=0 until the next expiry; the following interval is 3 cycles; no interval other than 10 or 3 occurs.
- start and stop asserted together in IDLE -> stays IDLE, tick=0. Assert RST during a tick pulse -> all outputs at reset values after that edge and period=DEFAULT_PERIOD.
- CNT_W=4, P=1 for 17 expiries -> tick_count wraps 15 -> 0 -> 1.
